// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller
// for the MEM stage. 32 lines x 32 bytes; tag = addr[31:10], index = addr[9:5],
// word = addr[4:2]. Misses run an optional dirty write-back, then a block refill.
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         p1_req_i,
    input  logic         p1_write_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic         mem_ack_i,
    input  logic [255:0] mem_data_i
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] MISS       = 3'd1;
    localparam logic [2:0] WRITEBACK  = 3'd2;
    localparam logic [2:0] READMISS   = 3'd3;
    localparam logic [2:0] READMISSOK = 3'd4;

    logic [2:0]   state_q;
    logic [31:0]  valid_q;
    logic [31:0]  dirty_q;
    logic [21:0]  tag_q  [32];
    logic [255:0] data_q [32];

    logic [4:0]   idx;
    logic [21:0]  tag;
    logic [2:0]   word;
    logic         hit;
    logic         store_hit;
    logic         fill;
    logic         unused_addr_lsb;

    // Address decode, hit detection, read mux and stall generation.
    always_comb begin
        idx             = p1_addr_i[9:5];
        tag             = p1_addr_i[31:10];
        word            = p1_addr_i[4:2];
        unused_addr_lsb = ^p1_addr_i[1:0];
        hit             = p1_req_i & valid_q[idx] & (tag_q[idx] == tag);
        store_hit       = (state_q == IDLE) & hit & p1_write_i;
        fill            = (state_q == READMISS) & mem_ack_i;
        p1_data_o       = data_q[idx][{word, 5'b0} +: 32];
        p1_stall_o      = (state_q != IDLE) | (p1_req_i & ~hit);
    end

    // Miss-handling FSM and the registered memory-side request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (p1_req_i && !hit) begin
                        state_q <= MISS;
                    end
                end
                MISS: begin
                    mem_req_o <= 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_q    <= WRITEBACK;
                        mem_we_o   <= 1'b1;
                        mem_addr_o <= {tag_q[idx], idx, 5'b0};
                        mem_data_o <= data_q[idx];
                    end else begin
                        state_q    <= READMISS;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {tag, idx, 5'b0};
                    end
                end
                WRITEBACK: begin
                    // Request stays asserted across the handoff to the refill.
                    if (mem_ack_i) begin
                        state_q    <= READMISS;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {tag, idx, 5'b0};
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        state_q   <= READMISSOK;
                        mem_req_o <= 1'b0;
                    end
                end
                READMISSOK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Valid/dirty bookkeeping: refill cleans and validates, store hit dirties.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays: refill writes the whole line, store hit one word.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_data_i;
        end else if (store_hit) begin
            data_q[idx][{word, 5'b0} +: 32] <= p1_data_i;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with a behavioural memory
// and a tag/valid/dirty reference model predicting stall and bus activity.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         p1_req_i, p1_write_i;
    logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
    logic         p1_stall_o;
    logic         mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;

    always #5 clk_i = ~clk_i;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_req_i(p1_req_i), .p1_write_i(p1_write_i),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Backing store and the architecturally expected word values.
    logic [255:0] backing [bit [31:0]];
    logic [31:0]  golden  [bit [31:0]];

    function automatic logic [255:0] back_blk(input logic [31:0] ba);
        logic [255:0] b;
        if (backing.exists(ba)) return backing[ba];
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = (ba + 32'(w * 4)) ^ 32'h5A5A_0000;
        return b;
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        logic [255:0] b;
        logic [31:0]  wa;
        wa = {a[31:2], 2'b0};
        if (golden.exists(wa)) return golden[wa];
        b = back_blk({a[31:5], 5'b0});
        return b[{a[4:2], 5'b0} +: 32];
    endfunction

    function automatic logic [255:0] gold_blk(input logic [31:0] ba);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = gold_word(ba + 32'(w * 4));
        return b;
    endfunction

    // Reference model of line state.
    bit        m_valid [32];
    bit        m_dirty [32];
    logic [21:0] m_tag [32];

    typedef struct { bit we; logic [31:0] addr; } txn_t;
    txn_t        mq[$];
    logic [31:0] dq[$];
    txn_t        t;

    int lat = 2;
    int cnt = 0;
    bit spurious = 1'b0;

    // Memory model: acks after lat waiting cycles, checks each transaction.
    always @(negedge clk_i) begin
        mem_ack_i = 1'b0;
        if (!rst_i) begin
            cnt = 0;
        end else if (mem_req_o) begin
            if (cnt >= lat) begin
                mem_ack_i = 1'b1;
                cnt = 0;
                if (mq.size() == 0) begin
                    check("mem_txn_unexpected", 1'b1, 1'b0);
                end else begin
                    t = mq.pop_front();
                    check("mem_we", mem_we_o, t.we);
                    check("mem_addr", mem_addr_o, t.addr);
                end
                if (mem_we_o) begin
                    check("wb_data", mem_data_o, gold_blk(mem_addr_o));
                    backing[mem_addr_o] = mem_data_o;
                end else begin
                    mem_data_i = back_blk(mem_addr_o);
                end
            end else begin
                cnt++;
            end
        end else begin
            cnt = 0;
            if (spurious) begin
                mem_ack_i  = 1'b1;
                mem_data_i = {8{32'hBAD0_BAD0}};
                spurious   = 1'b0;
            end
        end
    end

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [4:0]  idx;
        logic [21:0] tg;
        bit hit, wb;
        int exp_stall, exp_req, n, rq;
        idx = a[9:5];
        tg  = a[31:10];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        wb  = !hit && m_valid[idx] && m_dirty[idx];
        if (!hit) begin
            if (wb) mq.push_back('{we: 1'b1, addr: {m_tag[idx], idx, 5'b0}});
            mq.push_back('{we: 1'b0, addr: {a[31:5], 5'b0}});
        end
        exp_stall = hit ? 0 : (wb ? 2 * lat + 5 : lat + 4);
        exp_req   = hit ? 0 : (wb ? 2 * (lat + 1) : lat + 1);
        if (!wr) dq.push_back(gold_word(a));
        @(posedge clk_i); #1;
        p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = a; p1_data_i = d;
        n = 0; rq = 0;
        forever begin
            @(negedge clk_i);
            if (!p1_stall_o) break;
            n++;
            if (mem_req_o) rq++;
            if (n > 300) begin
                check("stall_timeout", 32'(n), 0);
                break;
            end
        end
        check("stall_cycles", 32'(n), 32'(exp_stall));
        check("req_cycles", 32'(rq), 32'(exp_req));
        if (!wr && dq.size() != 0) check("load_data", p1_data_o, dq.pop_front());
        @(posedge clk_i); #1;
        p1_req_i = 1'b0; p1_write_i = 1'b0;
        if (!hit) begin
            m_valid[idx] = 1'b1; m_tag[idx] = tg; m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            m_dirty[idx] = 1'b1;
            golden[{a[31:2], 2'b0}] = d;
        end
        check("mem_txn_drained", 32'(mq.size()), 0);
        mq.delete();
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        golden.delete();
        mq.delete();
        dq.delete();
    endtask

    initial begin
        logic [255:0] b;
        logic [31:0]  ra;
        rst_i = 1'b0; p1_req_i = 1'b0; p1_write_i = 1'b0;
        p1_addr_i = '0; p1_data_i = '0; mem_ack_i = 1'b0; mem_data_i = '0;
        b = back_blk(32'h40);
        b[64 +: 32] = 32'hDEAD_BEEF;
        backing[32'h40] = b;
        clear_model();

        #1;
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_we", mem_we_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_data", mem_data_o, '0);
        check("rst_stall_idle", p1_stall_o, 1'b0);
        p1_req_i = 1'b1; p1_addr_i = 32'h40; #1;
        check("rst_stall_req", p1_stall_o, 1'b1);
        p1_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        // Clean miss, then known word; store/load hits; dirty eviction.
        lat = 2;
        access(1'b0, 32'h40, 0);
        check("deadbeef", gold_word(32'h48), 32'hDEAD_BEEF);
        access(1'b0, 32'h48, 0);
        access(1'b1, 32'h44, 32'h1234_5678);
        access(1'b0, 32'h44, 0);
        access(1'b0, 32'h444, 0);
        // Store miss to a clean line, then eviction writes the stored value back.
        lat = 1;
        access(1'b1, 32'h8C, 32'hCAFE_F00D);
        access(1'b0, 32'h8C, 0);
        lat = 0;
        access(1'b0, 32'h488, 0);
        access(1'b0, 32'h8C, 0);

        // Spurious ack while idle must be ignored.
        spurious = 1'b1;
        repeat (3) @(negedge clk_i);
        access(1'b0, 32'h444, 0);
        access(1'b0, 32'h8C, 0);

        // Reset in the middle of a write-back.
        access(1'b1, 32'h448, 32'h0BAD_F00D);
        lat = 3;
        @(posedge clk_i); #1;
        p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h44;
        for (int i = 0; i < 20 && !(mem_req_o && mem_we_o); i++) @(negedge clk_i);
        check("wb_started", {mem_req_o, mem_we_o}, 2'b11);
        rst_i = 1'b0; #1;
        check("rst_wb_req", mem_req_o, 1'b0);
        check("rst_wb_we", mem_we_o, 1'b0);
        check("rst_wb_stall", p1_stall_o, 1'b1);
        p1_req_i = 1'b0;
        clear_model();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        lat = 1;
        access(1'b0, 32'h44, 0);
        access(1'b0, 32'h448, 0);

        // Mixed traffic across a few conflicting tags and latencies.
        for (int i = 0; i < 40; i++) begin
            ra = {20'h0, 2'($urandom_range(0, 3)), 10'h0};
            ra[9:5] = (i % 3 == 0) ? 5'd2 : ((i % 3 == 1) ? 5'd4 : 5'd31);
            ra[4:2] = 3'($urandom_range(0, 7));
            lat = $urandom_range(0, 3);
            access(1'($urandom_range(0, 1)), ra, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
